// File: rtl/raggedstone_spinn_aer_if_pkt_buffer.sv
// Elastic packet FIFO between the SpiNNaker link receiver and the spinn2aer mapper.
// First-word fall-through: a DEPTH-1 entry RAM feeds an output register counted in DEPTH.
module raggedstone_spinn_aer_if_pkt_buffer #(
  parameter int PKT_BITS  = 72,
  parameter int ADDR_BITS = 4,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PKT_BITS-1:0]  in_data,
  input  logic                 in_vld,
  output logic                 in_rdy,
  output logic [PKT_BITS-1:0]  out_data,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [ADDR_BITS:0]   count,
  output logic [ADDR_BITS:0]   hwm,
  input  logic                 hwm_clr,
  output logic [CNT_BITS-1:0]  pkt_cnt
);
  localparam int DEPTH = 2**ADDR_BITS;
  localparam logic [ADDR_BITS:0]   FULL = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH-2);

  logic [PKT_BITS-1:0]  ram_q [0:DEPTH-2];
  logic [ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_BITS:0]   count_q, count_d, hwm_q, hwm_d, ram_cnt;
  logic [PKT_BITS-1:0]  out_q;
  logic                 out_vld_q;
  logic [CNT_BITS-1:0]  pkt_q;
  logic push, pop, ram_empty, load_out, ram_rd, bypass, ram_wr;

  // Ready is registered-only: full blocks a push even when a pop happens this cycle.
  assign in_rdy   = !rst && (count_q < FULL);
  assign push     = in_vld && in_rdy;
  assign pop      = out_vld_q && out_rdy;
  assign ram_cnt  = count_q - {{ADDR_BITS{1'b0}}, out_vld_q};
  assign ram_empty = (ram_cnt == '0);
  // The output register refills whenever it is empty or being drained.
  assign load_out = !out_vld_q || pop;
  assign ram_rd   = load_out && !ram_empty;
  assign bypass   = load_out && ram_empty && push;
  assign ram_wr   = push && !bypass;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
    if (hwm_clr) hwm_d = count_d;
  end

  always_ff @(posedge clk) begin
    if (ram_wr) ram_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      hwm_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      pkt_q     <= '0;
    end else begin
      count_q <= count_d;
      hwm_q   <= hwm_d;
      if (pop)    pkt_q    <= pkt_q + 1'b1;
      if (ram_wr) wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (ram_rd) rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      if (load_out) begin
        out_vld_q <= ram_rd || bypass;
        if (ram_rd)      out_q <= ram_q[rd_ptr_q];
        else if (bypass) out_q <= in_data;
      end
    end
  end

  assign out_data = out_q;
  assign out_vld  = out_vld_q;
  assign count    = count_q;
  assign hwm      = hwm_q;
  assign pkt_cnt  = pkt_q;
endmodule

// File: tb/tb_raggedstone_spinn_aer_if_pkt_buffer.sv
// Bench for the packet buffer: directed scenarios plus random traffic against a queue model.
module tb_raggedstone_spinn_aer_if_pkt_buffer;
  logic        clk = 1'b0;
  logic        rst, in_vld, out_rdy, hwm_clr, in_rdy, out_vld;
  logic [71:0] in_data, out_data;
  logic [4:0]  count, hwm;
  logic [15:0] pkt_cnt;

  raggedstone_spinn_aer_if_pkt_buffer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .count(count),
    .hwm(hwm), .hwm_clr(hwm_clr), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0, total = 0, fails = 0;
  logic [71:0] q[$];
  int          m_hwm = 0;
  logic [15:0] m_pkt = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check model vs DUT, then advance the model at posedge.
  task automatic step(input bit v, input logic [71:0] d, input bit r,
                      input bit c = 1'b0, input bit rs = 1'b0);
    bit m_rdy, m_push, m_pop;
    @(negedge clk);
    in_vld = v; in_data = d; out_rdy = r; hwm_clr = c; rst = rs;
    #1;
    m_rdy = !rs && (q.size() < 16);
    chk("in_rdy", 128'(in_rdy), 128'(m_rdy));
    chk("out_vld", 128'(out_vld), 128'(q.size() > 0));
    if (q.size() > 0) chk("out_data", 128'(out_data), 128'(q[0]));
    chk("count", 128'(count), 128'(q.size()));
    chk("hwm", 128'(hwm), 128'(m_hwm));
    chk("pkt_cnt", 128'(pkt_cnt), 128'(m_pkt));
    m_push = v && m_rdy;
    m_pop  = r && (q.size() > 0);
    @(posedge clk);
    if (rs) begin
      q.delete(); m_hwm = 0; m_pkt = '0;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(d);
      if (m_pop) m_pkt = m_pkt + 16'd1;
      if (c || q.size() > m_hwm) m_hwm = q.size();
    end
  endtask

  function automatic logic [71:0] rnd72();
    return {$urandom(), $urandom(), 8'($urandom())};
  endfunction

  initial begin
    logic [71:0] seq;
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; hwm_clr = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_out_vld", 128'(out_vld), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_hwm", 128'(hwm), 128'(0));
    chk("rst_pkt_cnt", 128'(pkt_cnt), 128'(0));
    chk("rst_in_rdy", 128'(in_rdy), 128'(0));

    // Single packet held while the mapper stalls.
    step(1'b1, 72'h12_3456_789A_BCDE_F0A5, 1'b0);
    #1 chk("a5_vld", 128'(out_vld), 128'(1));
    chk("a5_data", 128'(out_data), 128'(72'h12_3456_789A_BCDE_F0A5));
    repeat (10) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);

    // Fill to full, attempt an overfill, then pop+push collision at full.
    for (int i = 1; i <= 16; i++) step(1'b1, 72'(i), 1'b0);
    #1 chk("full_count", 128'(count), 128'(16));
    chk("full_rdy", 128'(in_rdy), 128'(0));
    chk("full_hwm", 128'(hwm), 128'(16));
    step(1'b1, 72'h99, 1'b0);
    step(1'b1, 72'h77, 1'b1);
    #1 chk("full_pop_only", 128'(count), 128'(15));
    chk("rdy_after_pop", 128'(in_rdy), 128'(1));
    step(1'b1, 72'h77, 1'b0);
    repeat (17) step(1'b0, '0, 1'b1);
    #1 chk("drained", 128'(count), 128'(0));

    // Streaming at one packet per cycle.
    for (int i = 0; i < 100; i++) step(1'b1, 72'(1000 + i), 1'b1);
    step(1'b0, '0, 1'b1);

    // High-water clear and regrow.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, rnd72(), 1'b0);
    repeat (6) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    #1 chk("hwm_clr", 128'(hwm), 128'(3));
    repeat (2) step(1'b1, rnd72(), 1'b0);
    #1 chk("hwm_regrow", 128'(hwm), 128'(5));

    // Reset mid-operation with count=7 and both handshakes active.
    repeat (2) step(1'b1, rnd72(), 1'b0);
    step(1'b1, rnd72(), 1'b1, 1'b0, 1'b1);
    #1 chk("mid_rst_count", 128'(count), 128'(0));
    chk("mid_rst_vld", 128'(out_vld), 128'(0));
    chk("mid_rst_hwm", 128'(hwm), 128'(0));
    chk("mid_rst_pkt", 128'(pkt_cnt), 128'(0));
    step(1'b0, '0, 1'b1);
    step(1'b1, 72'h5A, 1'b1);

    // Random traffic, occasional clears and resets.
    for (int i = 0; i < 600; i++)
      step(1'(($urandom() & 3) != 0), rnd72(), 1'(($urandom() % 3) != 0),
           1'(($urandom() & 15) == 0), 1'(($urandom() & 127) == 0));

    // Delivered-packet counter wrap.
    seq = '0;
    while (m_pkt != 16'hFFFF) begin
      step(1'b1, seq, 1'b1);
      seq = seq + 72'd1;
    end
    step(1'b1, seq, 1'b1);
    #1 chk("pkt_wrap", 128'(pkt_cnt), 128'(0));
    repeat (3) step(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
